// File: rtl/systolic_operand_feeder.sv
// Operand feeder for a 2x2 output-stationary systolic array.
// Captures one A/B matrix pair, clears the accumulators, streams the
// skewed operands onto the west/north edges for three cycles, waits
// DRAIN_CYC cycles for the array to settle, then pulses done.
module systolic_operand_feeder #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] a_mat,
  input  logic [4*DATA_W-1:0] b_mat,
  output logic [DATA_W-1:0]   a_row0,
  output logic [DATA_W-1:0]   a_row1,
  output logic [DATA_W-1:0]   b_col0,
  output logic [DATA_W-1:0]   b_col1,
  output logic [1:0]          a_vld,
  output logic [1:0]          b_vld,
  output logic                acc_clr,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] FEED_LAST  = 4'd2;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DATA_W-1:0] a_q, b_q;

  logic [DATA_W-1:0]   a_row0_q, a_row0_d;
  logic [DATA_W-1:0]   a_row1_q, a_row1_d;
  logic [DATA_W-1:0]   b_col0_q, b_col0_d;
  logic [DATA_W-1:0]   b_col1_q, b_col1_d;
  logic [1:0]          a_vld_q, a_vld_d;
  logic [1:0]          b_vld_q, b_vld_d;
  logic                acc_clr_q, busy_q, done_q;

  logic                accept;

  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // Next-state and shared FEED/DRAIN cycle counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Skewed lane selection, decoded from the upcoming state so the
  // registered lanes line up with the FEED cycles they belong to.
  always_comb begin
    a_row0_d = '0;
    a_row1_d = '0;
    b_col0_d = '0;
    b_col1_d = '0;
    a_vld_d  = '0;
    b_vld_d  = '0;
    if (state_d == S_FEED) begin
      unique case (cnt_d)
        4'd0: begin
          a_row0_d = a_q[DATA_W-1:0];            // A11
          b_col0_d = b_q[DATA_W-1:0];            // B11
          a_vld_d  = 2'b01;
          b_vld_d  = 2'b01;
        end
        4'd1: begin
          a_row0_d = a_q[2*DATA_W-1:DATA_W];     // A12
          a_row1_d = a_q[3*DATA_W-1:2*DATA_W];   // A21
          b_col0_d = b_q[3*DATA_W-1:2*DATA_W];   // B21
          b_col1_d = b_q[2*DATA_W-1:DATA_W];     // B12
          a_vld_d  = 2'b11;
          b_vld_d  = 2'b11;
        end
        4'd2: begin
          a_row1_d = a_q[4*DATA_W-1:3*DATA_W];   // A22
          b_col1_d = b_q[4*DATA_W-1:3*DATA_W];   // B22
          a_vld_d  = 2'b10;
          b_vld_d  = 2'b10;
        end
        default: ;
      endcase
    end
  end

  // State, counter, operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_row0_q  <= '0;
      a_row1_q  <= '0;
      b_col0_q  <= '0;
      b_col1_q  <= '0;
      a_vld_q   <= '0;
      b_vld_q   <= '0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (accept) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      a_row0_q  <= a_row0_d;
      a_row1_q  <= a_row1_d;
      b_col0_q  <= b_col0_d;
      b_col1_q  <= b_col1_d;
      a_vld_q   <= a_vld_d;
      b_vld_q   <= b_vld_d;
      acc_clr_q <= (state_d == S_LOAD);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign a_row0  = a_row0_q;
  assign a_row1  = a_row1_q;
  assign b_col0  = b_col0_q;
  assign b_col1  = b_col1_q;
  assign a_vld   = a_vld_q;
  assign b_vld   = b_vld_q;
  assign acc_clr = acc_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: one instance with
// DRAIN_CYC=2 for the main scenarios, one with DRAIN_CYC=1 for drain length.
module tb_systolic_operand_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: DRAIN_CYC = 2
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_mat = '0, b_mat = '0;
  logic [3:0]  a_row0, a_row1, b_col0, b_col1;
  logic [1:0]  a_vld, b_vld;
  logic        acc_clr, busy, done;

  // Instance 1: DRAIN_CYC = 1
  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [15:0] a_mat1 = '0, b_mat1 = '0;
  logic [3:0]  a_row0_1, a_row1_1, b_col0_1, b_col1_1;
  logic [1:0]  a_vld1, b_vld1;
  logic        acc_clr1, busy1, done1;

  int passed = 0;
  int total  = 0;

  systolic_operand_feeder #(.DATA_W(4), .DRAIN_CYC(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat),
    .a_row0(a_row0), .a_row1(a_row1), .b_col0(b_col0), .b_col1(b_col1),
    .a_vld(a_vld), .b_vld(b_vld), .acc_clr(acc_clr), .busy(busy), .done(done)
  );

  systolic_operand_feeder #(.DATA_W(4), .DRAIN_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_mat(a_mat1), .b_mat(b_mat1),
    .a_row0(a_row0_1), .a_row1(a_row1_1), .b_col0(b_col0_1), .b_col1(b_col1_1),
    .a_vld(a_vld1), .b_vld(b_vld1), .acc_clr(acc_clr1), .busy(busy1), .done(done1)
  );

  // Advance one cycle; values observed afterwards belong to the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if ({a_row1, a_row0, b_col1, b_col0, a_vld, b_vld, acc_clr, busy, done, in_ready} !== '0)
      $display("FAIL reset_outputs: got %h expected 0",
               {a_row1, a_row0, b_col1, b_col0, a_vld, b_vld, acc_clr, busy, done, in_ready});
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1)
      $display("FAIL reset_release_ready: got %b/%b expected 1/1", in_ready, in_ready1);
    else passed++;
  endtask

  task automatic test_basic();
    logic [15:0] exp_lane [3];
    logic [3:0]  exp_vld  [3];
    exp_lane[0] = 16'h0501; exp_vld[0] = 4'b0101;
    exp_lane[1] = 16'h6732; exp_vld[1] = 4'b1111;
    exp_lane[2] = 16'h8040; exp_vld[2] = 4'b1010;
    a_mat = 16'h4321; b_mat = 16'h8765; in_valid = 1'b1;
    step();                           // accept edge 0 -> cycle 1
    in_valid = 1'b0;
    total++;
    if (acc_clr !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL basic_load: acc_clr/busy/ready got %b%b%b expected 110", acc_clr, busy, in_ready);
    else passed++;
    for (int t = 0; t < 3; t++) begin
      step();                         // cycles 2..4
      total++;
      if ({b_col1, b_col0, a_row1, a_row0} !== exp_lane[t] || {b_vld, a_vld} !== exp_vld[t] ||
          acc_clr !== 1'b0 || done !== 1'b0)
        $display("FAIL basic_feed_t%0d: lanes %h vld %b got, expected %h %b",
                 t, {b_col1, b_col0, a_row1, a_row0}, {b_vld, a_vld}, exp_lane[t], exp_vld[t]);
      else passed++;
    end
    for (int c = 5; c <= 6; c++) begin
      step();
      total++;
      if ({b_col1, b_col0, a_row1, a_row0, b_vld, a_vld} !== '0 || done !== 1'b0 || busy !== 1'b1)
        $display("FAIL basic_drain_c%0d: lanes %h done %b busy %b expected 0 0 1",
                 c, {b_col1, b_col0, a_row1, a_row0, b_vld, a_vld}, done, busy);
      else passed++;
    end
    step();                           // cycle 7
    total++;
    if (done !== 1'b1 || busy !== 1'b1)
      $display("FAIL basic_done_c7: done/busy got %b%b expected 11", done, busy);
    else passed++;
    step();                           // cycle 8
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_idle_c8: done/busy/ready got %b%b%b expected 001", done, busy, in_ready);
    else passed++;
  endtask

  task automatic test_busy_input();
    logic [15:0] exp_lane [3];
    logic [3:0]  exp_vld  [3];
    int          dones;
    exp_lane[0] = 16'h0501; exp_vld[0] = 4'b0101;
    exp_lane[1] = 16'h6732; exp_vld[1] = 4'b1111;
    exp_lane[2] = 16'h8040; exp_vld[2] = 4'b1010;
    dones = 0;
    a_mat = 16'h4321; b_mat = 16'h8765; in_valid = 1'b1;
    step();                           // cycle 1
    for (int t = 0; t < 3; t++) begin
      step();                         // cycles 2..4
      a_mat = 16'hFFFF;
      total++;
      if ({b_col1, b_col0, a_row1, a_row0} !== exp_lane[t] || {b_vld, a_vld} !== exp_vld[t])
        $display("FAIL busy_feed_t%0d: lanes %h vld %b got, expected %h %b",
                 t, {b_col1, b_col0, a_row1, a_row0}, {b_vld, a_vld}, exp_lane[t], exp_vld[t]);
      else passed++;
    end
    for (int c = 5; c <= 12; c++) begin
      step();
      if (c == 7) in_valid = 1'b0;    // drop before the IDLE cycle so no re-accept
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones !== 1)
      $display("FAIL busy_done_count: got %0d expected 1", dones);
    else passed++;
    a_mat = '0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] clr_seen, done_seen;
    clr_seen = '0; done_seen = '0;
    a_mat = 16'h4321; b_mat = 16'h8765; in_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 15) in_valid = 1'b0;   // stop before a third accept at edge 16
      clr_seen[c]  = acc_clr;
      done_seen[c] = done;
    end
    total++;
    if (clr_seen !== 24'h000202)
      $display("FAIL b2b_acc_clr_cycles: got %h expected 000202", clr_seen);
    else passed++;
    total++;
    if (done_seen !== 24'h008080)
      $display("FAIL b2b_done_cycles: got %h expected 008080", done_seen);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int dones;
    dones = 0;
    a_mat = 16'h4321; b_mat = 16'h8765; in_valid = 1'b1;
    step();                           // cycle 1
    in_valid = 1'b0;
    step();                           // cycle 2, t0
    step();                           // cycle 3, t1
    total++;
    if (a_row1 !== 4'h3 || a_vld !== 2'b11)
      $display("FAIL rst_pre_t1: a_row1 %h a_vld %b expected 3 11", a_row1, a_vld);
    else passed++;
    rst = 1'b1;
    step();
    total++;
    if ({a_row1, a_row0, b_col1, b_col0, a_vld, b_vld, acc_clr, busy, done} !== '0)
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {a_row1, a_row0, b_col1, b_col0, a_vld, b_vld, acc_clr, busy, done});
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_mid_ready: ready/busy got %b%b expected 10", in_ready, busy);
    else passed++;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    total++;
    if (dones !== 0)
      $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", dones);
    else passed++;
  endtask

  task automatic test_extreme();
    logic [15:0] exp_lane [3];
    logic [3:0]  exp_vld  [3];
    exp_lane[0] = 16'h0F0F; exp_vld[0] = 4'b0101;
    exp_lane[1] = 16'hFFFF; exp_vld[1] = 4'b1111;
    exp_lane[2] = 16'hF0F0; exp_vld[2] = 4'b1010;
    a_mat = 16'hFFFF; b_mat = 16'hFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step();
      total++;
      if ({b_col1, b_col0, a_row1, a_row0} !== exp_lane[t] || {b_vld, a_vld} !== exp_vld[t])
        $display("FAIL extreme_t%0d: lanes %h vld %b got, expected %h %b",
                 t, {b_col1, b_col0, a_row1, a_row0}, {b_vld, a_vld}, exp_lane[t], exp_vld[t]);
      else passed++;
    end
    repeat (5) step();
    total++;
    if (busy !== 1'b0 || {b_col1, b_col0, a_row1, a_row0} !== '0)
      $display("FAIL extreme_settle: busy %b lanes %h expected 0 0", busy,
               {b_col1, b_col0, a_row1, a_row0});
    else passed++;
  endtask

  task automatic test_drain1();
    logic [15:0] busy_seen, done_seen;
    busy_seen = '0; done_seen = '0;
    a_mat1 = 16'h4321; b_mat1 = 16'h8765; in_valid1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      in_valid1 = 1'b0;
      busy_seen[c] = busy1;
      done_seen[c] = done1;
    end
    total++;
    if (busy_seen !== 16'h007E)
      $display("FAIL drain1_busy_cycles: got %h expected 007e", busy_seen);
    else passed++;
    total++;
    if (done_seen !== 16'h0040)
      $display("FAIL drain1_done_cycles: got %h expected 0040", done_seen);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_input();
    test_back_to_back();
    test_mid_reset();
    test_extreme();
    test_drain1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
